// File: rtl/queue_sched_if.sv
// queue_sched_if: bundles the three handshake groups around queue_sched.
//   producer side : req, req_m, req_n (in)       gnt (out)
//   queue side    : q_full, q_empty, q_dout (in)  q_wr, q_m_din, q_n_din, q_rd, q_clr (out)
//   consumer side : out_ready (in)                out_valid, out_data (out)
// Directions above are from the scheduler's view (modport master); the
// environment (producers, queue, consumer) uses modport slave.
//
// Handshake rules: a producer write is transferred on a rising edge where
// req[i] and gnt[i] are both 1; the producer keeps req[i] and its fields
// stable until that happens. A consumer transfer happens on a rising edge
// where out_valid and out_ready are both 1; out_valid/out_data never change
// while out_valid=1 and out_ready=0.
interface queue_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int M_WIDTH = 8,
  parameter int N_WIDTH = 8
);
  logic [NUM_REQ-1:0]         req;
  logic [M_WIDTH*NUM_REQ-1:0] req_m;
  logic [N_WIDTH*NUM_REQ-1:0] req_n;
  logic [NUM_REQ-1:0]         gnt;
  logic                       q_wr;
  logic [M_WIDTH-1:0]         q_m_din;
  logic [N_WIDTH-1:0]         q_n_din;
  logic                       q_rd;
  logic                       q_clr;
  logic                       q_full;
  logic                       q_empty;
  logic [M_WIDTH+N_WIDTH-1:0] q_dout;
  logic                       out_valid;
  logic [M_WIDTH+N_WIDTH-1:0] out_data;
  logic                       out_ready;

  modport master (
    input  req, req_m, req_n, q_full, q_empty, q_dout, out_ready,
    output gnt, q_wr, q_m_din, q_n_din, q_rd, q_clr, out_valid, out_data
  );

  modport slave (
    output req, req_m, req_n, q_full, q_empty, q_dout, out_ready,
    input  gnt, q_wr, q_m_din, q_n_din, q_rd, q_clr, out_valid, out_data
  );
endinterface

// File: rtl/queue_sched.sv
// queue_sched: front-end controller for the pointer-ring queue.
//   - arbitrates NUM_REQ producers onto the queue write port (round robin)
//   - drains the queue head into a one-entry output register (valid/ready)
//   - tracks queue occupancy and sequences flush: IDLE -> FLUSH -> RECOV
// Ports:
//   clk       rising-edge clock
//   clr       asynchronous active-low reset
//   flush     one-cycle pulse; discards queued and held data (IDLE only)
//   bus       queue_sched_if.master (producer, queue and consumer signals)
//   count     entries in the queue, not counting the output register
//   busy      FSM is not in IDLE
//   dbg_state current FSM state (0 IDLE, 1 FLUSH, 2 RECOV)
// Build option: define QUEUE_SCHED_FIXED_PRIO_EN for fixed priority
// arbitration (lowest index wins, no rotating pointer).
module queue_sched #(
  parameter int NUM_REQ  = 4,
  parameter int M_WIDTH  = 8,
  parameter int N_WIDTH  = 8,
  parameter int Q_LENGTH = 16,
  parameter int CNT_W    = $clog2(Q_LENGTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             flush,
  queue_sched_if.master    bus,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE = 2'd0, FLUSH = 2'd1, RECOV = 2'd2} state_t;

  state_t                     state_q, state_d;
  logic                       out_valid_q;
  logic [M_WIDTH+N_WIDTH-1:0] out_data_q;
  logic [PTR_W-1:0]           win_idx;
  logic                       win_found;
  logic                       grant_en;
  logic                       flush_go;

  // FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (flush) state_d = FLUSH;
      FLUSH:   state_d = RECOV;
      RECOV:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign flush_go  = (state_q == IDLE) && flush;
  assign grant_en  = (state_q == IDLE) && !bus.q_full && !flush;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;
  // Decoded straight from the state flop so the queue sees a clean clear.
  assign bus.q_clr = (state_q == FLUSH);

  // Winner selection
`ifdef QUEUE_SCHED_FIXED_PRIO_EN
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    // Scan downward so the lowest requesting index is the last to write.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(i);
      end
    end
  end
`else
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W:0]   pos;

  // Search starts at rr_ptr and wraps modulo NUM_REQ; pos carries one spare
  // bit so the wrap works for non power-of-two NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    pos       = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      pos = {1'b0, rr_ptr} + (PTR_W+1)'(j);
      if (pos >= (PTR_W+1)'(NUM_REQ)) pos = pos - (PTR_W+1)'(NUM_REQ);
      if (!win_found && bus.req[pos[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = pos[PTR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rr_ptr <= '0;
    end else if (bus.q_wr) begin
      rr_ptr <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end
`endif

  // Write port
  always_comb begin
    bus.gnt     = '0;
    bus.q_m_din = '0;
    bus.q_n_din = '0;
    if (grant_en && win_found) begin
      bus.gnt[win_idx] = 1'b1;
      bus.q_m_din      = bus.req_m[win_idx*M_WIDTH +: M_WIDTH];
      bus.q_n_din      = bus.req_n[win_idx*N_WIDTH +: N_WIDTH];
    end
  end

  assign bus.q_wr = |bus.gnt;

  // Read port: pop whenever the output register is empty or being consumed
  // this cycle, which gives back-to-back transfers with no bubble.
  assign bus.q_rd = (state_q == IDLE) && !bus.q_empty &&
                    (!out_valid_q || bus.out_ready) && !flush;

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      count       <= '0;
    end else begin
      state_q <= state_d;
      if (flush_go) begin
        // out_data is left as is; it is meaningless while out_valid=0.
        out_valid_q <= 1'b0;
        count       <= '0;
      end else begin
        if (bus.q_rd) begin
          out_data_q  <= bus.q_dout;
          out_valid_q <= 1'b1;
        end else if (bus.out_ready && out_valid_q) begin
          out_valid_q <= 1'b0;
        end
        count <= count + CNT_W'(bus.q_wr) - CNT_W'(bus.q_rd);
      end
    end
  end

  a_no_wr_full:  assert property (@(posedge clk) disable iff (!clr) !(bus.q_wr && bus.q_full));
  a_no_rd_empty: assert property (@(posedge clk) disable iff (!clr) !(bus.q_rd && bus.q_empty));

endmodule

// File: tb/tb_queue_sched.sv
module tb_queue_sched;
  localparam int NR = 4;
  localparam int MW = 8;
  localparam int NW = 8;
  localparam int DW = MW + NW;

  logic          clk;
  logic          clr;
  logic          flush;
  logic [3:0]    count;
  logic          busy;
  logic [1:0]    dbg_state;

  queue_sched_if #(.NUM_REQ(NR), .M_WIDTH(MW), .N_WIDTH(NW)) sif ();

  queue_sched #(.NUM_REQ(NR), .M_WIDTH(MW), .N_WIDTH(NW), .Q_LENGTH(16)) dut (
    .clk(clk), .clr(clr), .flush(flush), .bus(sif.master),
    .count(count), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // queue model: 15 usable entries, head visible on q_dout
  logic [DW-1:0] mem [0:15];
  logic [4:0]    m_cnt;
  logic [3:0]    m_head, m_tail;

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_cnt <= '0; m_head <= '0; m_tail <= '0;
    end else if (sif.q_clr) begin
      m_cnt <= '0; m_head <= '0; m_tail <= '0;
    end else begin
      if (sif.q_wr) begin
        mem[m_tail] <= {sif.q_m_din, sif.q_n_din};
        m_tail      <= m_tail + 4'd1;
      end
      if (sif.q_rd) m_head <= m_head + 4'd1;
      m_cnt <= m_cnt + 5'(sif.q_wr) - 5'(sif.q_rd);
    end
  end

  assign sif.q_full  = (m_cnt == 5'd15);
  assign sif.q_empty = (m_cnt == 5'd0);
  assign sif.q_dout  = (m_cnt != 5'd0) ? mem[m_head] : '0;

  // scoreboard and reference state
  logic [DW-1:0] exp_q[$];
  int            total = 0;
  int            bad   = 0;
  int            m_ptr = 0;
  int            m_fsm = 0;
  logic [NR-1:0] obs_gnt;

  function automatic logic [NR-1:0] model_gnt(input logic [NR-1:0] r, input int ptr);
    int idx;
    for (int k = 0; k < NR; k++) begin
      idx = (ptr + k) % NR;
      if (r[idx]) return NR'(1) << idx;
    end
    return '0;
  endfunction

  // One clock: sample at negedge, update reference, end at posedge+1.
  task automatic step();
    logic [NR-1:0] eg;
    logic [DW-1:0] e;
    @(negedge clk);
    if (sif.out_valid && sif.out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected: got %h, scoreboard empty", sif.out_data);
      end else begin
        e = exp_q.pop_front();
        if (sif.out_data !== e) begin
          bad++;
          $display("FAIL out_data: got %h want %h", sif.out_data, e);
        end
      end
    end
    eg = (m_fsm == 0 && !flush && !sif.q_full) ? model_gnt(sif.req, m_ptr) : '0;
    obs_gnt = sif.gnt;
    total++;
    if (sif.gnt !== eg) begin
      bad++;
      $display("FAIL gnt: got %b want %b", sif.gnt, eg);
    end
    total++;
    if (busy !== (m_fsm != 0) || sif.q_clr !== (m_fsm == 1) || dbg_state !== 2'(m_fsm)) begin
      bad++;
      $display("FAIL fsm_outs: busy=%b q_clr=%b dbg=%0d want state %0d", busy, sif.q_clr, dbg_state, m_fsm);
    end
    for (int i = 0; i < NR; i++) begin
      if (eg[i]) begin
        exp_q.push_back({sif.req_m[i*MW +: MW], sif.req_n[i*NW +: NW]});
`ifndef QUEUE_SCHED_FIXED_PRIO_EN
        m_ptr = (i + 1) % NR;
`endif
      end
    end
    if (m_fsm == 0 && flush) begin
      m_fsm = 1;
      exp_q.delete();
    end else if (m_fsm == 1) m_fsm = 2;
    else if (m_fsm == 2) m_fsm = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    sif.req = '0; sif.out_ready = 1'b1; flush = 1'b0;
    n = 0;
    while (n < 40 && !(exp_q.size() == 0 && !sif.out_valid && m_cnt == 0)) begin
      step();
      n++;
    end
    total++;
    if (exp_q.size() != 0 || sif.out_valid !== 1'b0 || count !== 4'd0) begin
      bad++;
      $display("FAIL drain: left=%0d out_valid=%b count=%0d want 0/0/0", exp_q.size(), sif.out_valid, count);
    end
  endtask

  task automatic test_reset();
    clr = 1'b0; flush = 1'b0;
    sif.req = '0; sif.req_m = '0; sif.req_n = '0; sif.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (sif.out_valid !== 1'b0 || count !== 4'd0 || sif.gnt !== 4'd0 || sif.q_clr !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset: ov=%b cnt=%0d gnt=%b q_clr=%b busy=%b want all 0",
               sif.out_valid, count, sif.gnt, sif.q_clr, busy);
    end
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] seq [0:4];
`ifdef QUEUE_SCHED_FIXED_PRIO_EN
    seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    sif.req_m = 32'h3D2C1B0A; sif.req_n = 32'hD3C2B1A0;
    sif.req = 4'b1111; sif.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (obs_gnt !== seq[i]) begin
        bad++;
        $display("FAIL rr_seq[%0d]: got %b want %b", i, obs_gnt, seq[i]);
      end
      total++;
      if (count !== 4'd1) begin
        bad++;
        $display("FAIL rr_count[%0d]: got %0d want 1", i, count);
      end
      if (i >= 1) begin
        total++;
        if (sif.out_valid !== 1'b1) begin
          bad++;
          $display("FAIL rr_out_valid[%0d]: got %b want 1", i, sif.out_valid);
        end
      end
    end
  endtask

  task automatic test_two_req();
    logic [NR-1:0] prev;
    sif.req = 4'b1010; sif.out_ready = 1'b1;
    prev = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
`ifdef QUEUE_SCHED_FIXED_PRIO_EN
      if (obs_gnt !== 4'b0010) begin
        bad++;
        $display("FAIL fixed_prio[%0d]: got %b want 0010", i, obs_gnt);
      end
`else
      if (i > 0 && obs_gnt !== ((prev == 4'b0010) ? 4'b1000 : 4'b0010)) begin
        bad++;
        $display("FAIL rr_alternate[%0d]: got %b after %b", i, obs_gnt, prev);
      end
`endif
      prev = obs_gnt;
    end
  endtask

  task automatic test_full_backpressure();
    int n;
    sif.req = 4'b0001; sif.out_ready = 1'b0; sif.req_m = 32'h000000E5;
    n = 0;
    while (n < 40 && count != 4'd15) begin
      sif.req_n = 32'(n);
      step();
      n++;
    end
    total++;
    if (count !== 4'd15) begin
      bad++;
      $display("FAIL full_count: got %0d want 15", count);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (obs_gnt !== 4'b0000 || count !== 4'd15) begin
        bad++;
        $display("FAIL full_hold[%0d]: gnt=%b count=%0d want 0000/15", i, obs_gnt, count);
      end
    end
    drain();
  endtask

  task automatic test_handshake();
    logic [NR-1:0] rq [0:5];
    logic          rdy [0:5];
    rq  = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    rdy = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      sif.req = rq[i]; sif.out_ready = rdy[i];
      sif.req_m = 32'($urandom_range(0, 255)); sif.req_n = 32'($urandom_range(0, 255));
      step();
      if (i == 3) begin
        total++;
        if (sif.out_valid !== 1'b1) begin
          bad++;
          $display("FAIL hs_hold: out_valid got %b want 1", sif.out_valid);
        end
      end
    end
    total++;
    if (exp_q.size() != 0 || sif.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL hs_end: left=%0d out_valid=%b want 0/0", exp_q.size(), sif.out_valid);
    end
  endtask

  task automatic test_flush();
    logic [NR-1:0] want [0:2];
    want = '{4'b0000, 4'b0000, 4'b0010};
    sif.req = 4'b0001; sif.out_ready = 1'b0; sif.req_m = 32'h0000005A;
    for (int i = 0; i < 6; i++) begin
      sif.req_n = 32'(i);
      step();
    end
    total++;
    if (count !== 4'd5 || sif.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL pre_flush: count=%0d ov=%b want 5/1", count, sif.out_valid);
    end
    sif.req = 4'b0010; flush = 1'b1;
    step();
    flush = 1'b0;
    total++;
    if (sif.q_clr !== 1'b1 || sif.out_valid !== 1'b0 || count !== 4'd0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL flush_state: q_clr=%b ov=%b count=%0d busy=%b want 1/0/0/1",
               sif.q_clr, sif.out_valid, count, busy);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (obs_gnt !== want[i]) begin
        bad++;
        $display("FAIL flush_gnt[%0d]: got %b want %b", i, obs_gnt, want[i]);
      end
    end
  endtask

  task automatic test_reset_mid_flush();
    sif.req = '0; sif.out_ready = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    clr = 1'b0;
    #1;
    total++;
    if (sif.q_clr !== 1'b0 || busy !== 1'b0 || count !== 4'd0 || sif.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_flush: q_clr=%b busy=%b count=%0d ov=%b want 0/0/0/0",
               sif.q_clr, busy, count, sif.out_valid);
    end
    m_fsm = 0; m_ptr = 0; exp_q.delete();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    sif.req = 4'b0100; sif.req_m = 32'h00770000; sif.req_n = 32'h00880000;
    step();
    drain();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    drain();
    test_two_req();
    drain();
    test_full_backpressure();
    test_handshake();
    test_flush();
    drain();
    test_reset_mid_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // overall time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
